// File: rtl/lsb_pkg.sv
// Shared constants for the lsb_db board I/O block.
// Covers the register map, the red-LED set/clear flag and the seven-segment table.
package lsb_pkg;

  localparam logic [1:0] LSB_ADDR_IO   = 2'd0;
  localparam logic [1:0] LSB_ADDR_LEDR = 2'd1;
  localparam logic [1:0] LSB_ADDR_EVT  = 2'd2;
  localparam logic [1:0] LSB_ADDR_HEX  = 2'd3;

  localparam int unsigned LSB_SETCLR_BIT = 31;
  localparam int unsigned LSB_SEG_W      = 7;
  localparam int unsigned LSB_NIB_W      = 4;

  // Active-low gfedcba patterns, indexed by the nibble value 0..F.
  localparam logic [15:0][LSB_SEG_W-1:0] LSB_SEG7 = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/lsb_db_debounce.sv
// Two-flop synchroniser followed by a per-bit stability debouncer.
// A bit only changes after DEB_CYCLES consecutive cycles of disagreement.
module debounce #(
  parameter int unsigned WIDTH      = 1,
  parameter int unsigned DEB_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_raw,
  output logic [WIDTH-1:0] o_stable
);

  localparam int unsigned      CNT_W    = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic [CNT_W-1:0] r_cnt;
    logic             r_stable;

    // Counter tracks consecutive cycles where the synced input disagrees.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_cnt    <= '0;
        r_stable <= 1'b0;
      end else if (r_sync2[i] == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_cnt    <= '0;
        r_stable <= r_sync2[i];
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end

    assign o_stable[i] = r_stable;
  end

endmodule

// File: rtl/lsb_db.sv
// LEDs/switches/buttons I/O block with debounced inputs, button events and irq.
// Optional seven-segment hex output is enabled by defining LSB_DB_HEX_EN.
module lsb_db
  import lsb_pkg::*;
#(
  parameter int unsigned NUM_BTN    = 4,
  parameter int unsigned NUM_SWI    = 18,
  parameter int unsigned NUM_LEDR   = 18,
  parameter int unsigned NUM_LEDG   = 9,
  parameter int unsigned NUM_HEX    = 8,
  parameter int unsigned DEB_CYCLES = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stb,
  input  logic                  we,
  input  logic [1:0]            addr,
  input  logic [31:0]           data_in,
  output logic [31:0]           data_out,
  output logic                  ack,
  output logic                  irq,
  input  logic [NUM_LEDR-1:0]   leds_r_in,
  input  logic [NUM_BTN-1:0]    btn_in_n,
  input  logic [NUM_SWI-1:0]    swi_in,
  output logic [NUM_LEDR-1:0]   leds_r,
  output logic [NUM_LEDG-1:0]   leds_g,
  output logic [7*NUM_HEX-1:0]  hex_n,
  output logic [NUM_BTN-1:0]    btn_out,
  output logic [NUM_SWI-1:0]    swi_out
);

  logic [NUM_BTN-1:0]  w_btn_db;
  logic [NUM_SWI-1:0]  w_swi_db;
  logic [NUM_BTN-1:0]  w_btn_pressed;
  logic [NUM_BTN-1:0]  w_evt_set;
  logic [NUM_BTN-1:0]  w_evt_clr;
  logic                w_wr;
  logic                w_wr_io;
  logic                w_wr_ledr;
  logic                w_wr_evt;
  logic [31:0]         w_hex_rd;
  logic [31:0]         w_rdata;

  logic [NUM_LEDG-1:0] r_ledg;
  logic [NUM_LEDR-1:0] r_red;
  logic [NUM_LEDR-1:0] r_ledr_in;
  logic [NUM_BTN-1:0]  r_btn_prev;
  logic [NUM_BTN-1:0]  r_evt;
  logic                r_irq;

  assign w_btn_pressed = ~btn_in_n;

  debounce #(.WIDTH(NUM_BTN), .DEB_CYCLES(DEB_CYCLES)) u_btn_db (
    .clk      (clk),
    .rst      (rst),
    .i_raw    (w_btn_pressed),
    .o_stable (w_btn_db)
  );

  debounce #(.WIDTH(NUM_SWI), .DEB_CYCLES(DEB_CYCLES)) u_swi_db (
    .clk      (clk),
    .rst      (rst),
    .i_raw    (swi_in),
    .o_stable (w_swi_db)
  );

  assign w_wr      = stb & we;
  assign w_wr_io   = w_wr && (addr == LSB_ADDR_IO);
  assign w_wr_ledr = w_wr && (addr == LSB_ADDR_LEDR);
  assign w_wr_evt  = w_wr && (addr == LSB_ADDR_EVT);

  // Event bits set on a debounced press edge; set beats a same-cycle clear.
  assign w_evt_set = w_btn_db & ~r_btn_prev;
  assign w_evt_clr = w_wr_evt ? data_in[NUM_BTN-1:0] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ledg     <= '0;
      r_red      <= '0;
      r_ledr_in  <= '0;
      r_btn_prev <= '0;
      r_evt      <= '0;
      r_irq      <= 1'b0;
    end else begin
      if (w_wr_io) begin
        r_ledg <= data_in[NUM_LEDG-1:0];
      end
      if (w_wr_ledr) begin
        r_red <= data_in[LSB_SETCLR_BIT] ? (r_red | data_in[NUM_LEDR-1:0])
                                         : (r_red & ~data_in[NUM_LEDR-1:0]);
      end
      r_ledr_in  <= leds_r_in;
      r_btn_prev <= w_btn_db;
      r_evt      <= (r_evt & ~w_evt_clr) | w_evt_set;
      r_irq      <= |r_evt;
    end
  end

`ifdef LSB_DB_HEX_EN
  logic                 w_wr_hex;
  logic [31:0]          r_hex;
  logic [7*NUM_HEX-1:0] r_hex_n;

  assign w_wr_hex = w_wr && (addr == LSB_ADDR_HEX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hex   <= '0;
      r_hex_n <= '1;
    end else begin
      if (w_wr_hex) begin
        r_hex <= data_in;
      end
      for (int k = 0; k < int'(NUM_HEX); k++) begin
        r_hex_n[LSB_SEG_W*k +: LSB_SEG_W] <= LSB_SEG7[r_hex[LSB_NIB_W*k +: LSB_NIB_W]];
      end
    end
  end

  assign w_hex_rd = r_hex;
  assign hex_n    = r_hex_n;
`else
  logic w_unused_data;

  assign w_unused_data = ^data_in;
  assign w_hex_rd      = '0;
  assign hex_n         = '1;
`endif

  always_comb begin
    w_rdata = '0;
    case (addr)
      LSB_ADDR_IO:   w_rdata = (32'(w_swi_db) << 8) | 32'(w_btn_db);
      LSB_ADDR_LEDR: w_rdata = 32'(r_red);
      LSB_ADDR_EVT:  w_rdata = 32'(r_evt);
      LSB_ADDR_HEX:  w_rdata = w_hex_rd;
      default:       w_rdata = '0;
    endcase
  end

  assign data_out = (stb && !we) ? w_rdata : '0;
  assign ack      = stb;
  assign irq      = r_irq;
  assign leds_r   = r_red | r_ledr_in;
  assign leds_g   = r_ledg;
  assign btn_out  = w_btn_db;
  assign swi_out  = w_swi_db;

endmodule

// File: tb/tb_lsb_db.sv
// Directed bench for lsb_db with a behavioural model checked every cycle.
// Honours LSB_DB_HEX_EN the same way as the design.
module tb_lsb_db;

  localparam int NB  = 4;
  localparam int NS  = 18;
  localparam int NR  = 18;
  localparam int NG  = 9;
  localparam int NH  = 8;
  localparam int DEB = 4;
  localparam int NI  = NB + NS;

  logic            clk = 1'b0;
  logic            clk_en = 1'b0;
  logic            rst;
  logic            stb, we;
  logic [1:0]      addr;
  logic [31:0]     data_in, data_out;
  logic            ack, irq;
  logic [NR-1:0]   leds_r_in, leds_r;
  logic [NB-1:0]   btn_in_n, btn_out;
  logic [NS-1:0]   swi_in, swi_out;
  logic [NG-1:0]   leds_g;
  logic [7*NH-1:0] hex_n;

  int n_checks = 0;
  int n_fail   = 0;

  lsb_db #(
    .NUM_BTN(NB), .NUM_SWI(NS), .NUM_LEDR(NR), .NUM_LEDG(NG),
    .NUM_HEX(NH), .DEB_CYCLES(DEB)
  ) dut (
    .clk(clk), .rst(rst), .stb(stb), .we(we), .addr(addr),
    .data_in(data_in), .data_out(data_out), .ack(ack), .irq(irq),
    .leds_r_in(leds_r_in), .btn_in_n(btn_in_n), .swi_in(swi_in),
    .leds_r(leds_r), .leds_g(leds_g), .hex_n(hex_n),
    .btn_out(btn_out), .swi_out(swi_out)
  );

  always #5 clk = clk_en ? ~clk : 1'b0;

  // ---------------- behavioural model ----------------
  logic [NI-1:0]   m_p1, m_p2, m_stab;
  logic [NI-1:0]   m_hist [DEB];
  logic [NB-1:0]   m_seen, m_evt, m_rise;
  logic            m_irq, m_same;
  logic [NR-1:0]   m_red, m_lin;
  logic [NG-1:0]   m_ledg;
  logic [31:0]     m_hex;
  logic [7*NH-1:0] m_hexn;

  function automatic logic [6:0] seg(input logic [3:0] n);
    case (n)
      4'h0: seg = 7'b1000000; 4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100; 4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001; 4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010; 4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000; 4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000; 4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110; 4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110; default: seg = 7'b0001110;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_p1 = '0; m_p2 = '0; m_stab = '0;
      for (int k = 0; k < DEB; k++) m_hist[k] = '0;
      m_seen = '0; m_evt = '0; m_irq = 1'b0;
      m_red = '0; m_lin = '0; m_ledg = '0; m_hex = '0; m_hexn = '1;
    end else begin
      // irq mirrors last cycle's events; a press is seen one cycle after debounce
      m_irq  = |m_evt;
      m_rise = m_stab[NB-1:0] & ~m_seen;
      m_seen = m_stab[NB-1:0];
      if (stb && we && addr == 2'd2) m_evt = m_evt & ~data_in[NB-1:0];
      m_evt = m_evt | m_rise;
      if (stb && we && addr == 2'd0) m_ledg = data_in[NG-1:0];
      if (stb && we && addr == 2'd1)
        m_red = data_in[31] ? (m_red | data_in[NR-1:0]) : (m_red & ~data_in[NR-1:0]);
      m_lin = leds_r_in;
`ifdef LSB_DB_HEX_EN
      for (int k = 0; k < NH; k++) m_hexn[7*k +: 7] = seg(m_hex[4*k +: 4]);
      if (stb && we && addr == 2'd3) m_hex = data_in;
`endif
      // a bit follows the synced input once its last DEB samples all agree
      for (int k = DEB-1; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = m_p2;
      for (int i = 0; i < NI; i++) begin
        m_same = 1'b1;
        for (int k = 1; k < DEB; k++)
          if (m_hist[k][i] != m_hist[0][i]) m_same = 1'b0;
        if (m_same) m_stab[i] = m_hist[0][i];
      end
      m_p2 = m_p1;
      m_p1 = {swi_in, ~btn_in_n};
    end
  end

  function automatic logic [31:0] exp_rd();
    if (!(stb && !we)) return 32'h0;
    case (addr)
      2'd0:    return (32'(m_stab[NI-1:NB]) << 8) | 32'(m_stab[NB-1:0]);
      2'd1:    return 32'(m_red);
      2'd2:    return 32'(m_evt);
`ifdef LSB_DB_HEX_EN
      default: return m_hex;
`else
      default: return 32'h0;
`endif
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("ack",      64'(ack),      64'(stb));
      chk("data_out", 64'(data_out), 64'(exp_rd()));
      chk("leds_g",   64'(leds_g),   64'(m_ledg));
      chk("leds_r",   64'(leds_r),   64'(m_red | m_lin));
      chk("btn_out",  64'(btn_out),  64'(m_stab[NB-1:0]));
      chk("swi_out",  64'(swi_out),  64'(m_stab[NI-1:NB]));
      chk("irq",      64'(irq),      64'(m_irq));
      chk("hex_n",    64'(hex_n),    64'(m_hexn));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    stb = 1'b1; we = 1'b1; addr = a; data_in = d;
    step(1);
    stb = 1'b0; we = 1'b0; data_in = '0;
  endtask

  task automatic read_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
    stb = 1'b1; we = 1'b0; addr = a;
    #1;
    chk(name, 64'(data_out), 64'(exp));
    stb = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    stb = 1'b0; we = 1'b0; addr = '0; data_in = '0;
    leds_r_in = '0; btn_in_n = '1; swi_in = '0;
    #3;
    chk("rst_hex_n",   64'(hex_n),   {8'h0, {56{1'b1}}});
    chk("rst_leds_g",  64'(leds_g),  64'h0);
    chk("rst_leds_r",  64'(leds_r),  64'h0);
    chk("rst_irq",     64'(irq),     64'h0);
    chk("rst_btn_out", 64'(btn_out), 64'h0);
    for (int a = 0; a < 4; a++) begin
      read_chk("rst_read", 2'(a), 32'h0);
      chk("rst_ack", 64'(ack), 64'h0);
    end
    #2 rst = 1'b0;
    clk_en = 1'b1;
    step(3);

    // 3-cycle glitch must not propagate
    btn_in_n[0] = 1'b0; step(3);
    btn_in_n[0] = 1'b1; step(8);
    chk("glitch_btn", 64'(btn_out), 64'h0);
    read_chk("glitch_evt", 2'd2, 32'h0);

    // clean press: btn_out after 6 edges, event next, irq after that
    btn_in_n[0] = 1'b0; step(5);
    chk("press_btn_early", 64'(btn_out[0]), 64'h0);
    step(1);
    chk("press_btn", 64'(btn_out[0]), 64'h1);
    step(1);
    read_chk("press_evt", 2'd2, 32'h1);
    chk("press_irq_early", 64'(irq), 64'h0);
    step(1);
    chk("press_irq", 64'(irq), 64'h1);
    step(2);

    // clear racing a new press edge: set wins
    btn_in_n[0] = 1'b1; step(10);
    btn_in_n[0] = 1'b0; step(6);
    bus_write(2'd2, 32'h1);
    read_chk("race_evt", 2'd2, 32'h1);
    bus_write(2'd2, 32'h1);
    read_chk("clear_evt", 2'd2, 32'h0);
    step(1);
    chk("clear_irq", 64'(irq), 64'h0);

    // red LED set/clear and hardware OR
    bus_write(2'd1, 32'h8000000F);
    read_chk("red_set", 2'd1, 32'hF);
    bus_write(2'd1, 32'h00000005);
    read_chk("red_clr", 2'd1, 32'hA);
    leds_r_in = 18'h10; step(1);
    chk("red_or", 64'(leds_r), 64'h1A);

    // IO packing and green LEDs
    btn_in_n = '1; swi_in = 18'h3FFFF; step(8);
    read_chk("io_read", 2'd0, 32'h03FFFF00);
    bus_write(2'd0, 32'h1FF);
    chk("leds_g", 64'(leds_g), 64'h1FF);

    bus_write(2'd3, 32'h0000008F);
    step(1);
`ifdef LSB_DB_HEX_EN
    chk("hex_n", 64'(hex_n), 64'({{6{7'b1000000}}, 7'b0000000, 7'b0001110}));
    read_chk("hex_read", 2'd3, 32'h8F);
`else
    chk("hex_n", 64'(hex_n), {8'h0, {56{1'b1}}});
    read_chk("hex_read", 2'd3, 32'h0);
`endif

    // reset mid-debounce restarts the count from scratch
    btn_in_n[1] = 1'b0; step(3);
    rst = 1'b1; #1;
    chk("mid_rst_btn", 64'(btn_out), 64'h0);
    chk("mid_rst_ledg", 64'(leds_g), 64'h0);
    rst = 1'b0;
    step(5);
    chk("mid_rst_btn_early", 64'(btn_out[1]), 64'h0);
    step(1);
    chk("mid_rst_btn_late", 64'(btn_out[1]), 64'h1);
    chk("mid_rst_red", 64'(leds_r), 64'h10);
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
